// File: rtl/flash_adc_pkg.sv
// Shared constants, types and helpers for the 5-bit flash ADC.
// The reference ladder is uniform: tap i sits at VREF_STEP*(i+1).
package flash_adc_pkg;

  localparam int unsigned NUM_COMP  = 31;
  localparam int unsigned VREF_STEP = 8;
  localparam int unsigned IN_W      = 8;
  localparam int unsigned OUT_W     = 5;

  typedef logic [IN_W-1:0]     sample_t;
  typedef logic [NUM_COMP-1:0] therm_t;
  typedef logic [OUT_W-1:0]    code_t;

  function automatic sample_t vref(input int unsigned idx);
    return sample_t'((idx + 1) * VREF_STEP);
  endfunction

  function automatic code_t bin2gray(input code_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/adc_comparator_ladder.sv
// Combinational comparator ladder with single-bubble suppression.
// Produces a thermometer code where tc[i] = diff > vref(i), cleaned of isolated ones.
module adc_comparator_ladder
  import flash_adc_pkg::*;
(
  input  logic [IN_W-1:0]     diff,
  output logic [NUM_COMP-1:0] therm_tc
);

  therm_t therm;

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < NUM_COMP; i++) begin
      therm[i] = (diff > vref(i));
    end
  end

  // A tap only counts if the tap below it also fired.
  always_comb begin
    therm_tc    = '0;
    therm_tc[0] = therm[0];
    for (int unsigned i = 1; i < NUM_COMP; i++) begin
      therm_tc[i] = therm[i] & therm[i-1];
    end
  end

endmodule

// File: rtl/flash_adc_5bit_top.sv
// Two-stage flash ADC: stage 1 registers the wrapped input difference,
// stage 2 registers the Gray-coded population count of the ladder output.
module flash_adc_5bit_top
  import flash_adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   vin_p,
  input  logic [IN_W-1:0]   vin_n,
  output logic [OUT_W-1:0]  gray_out,
  output logic              out_valid
);

  sample_t diff_d, diff_q;
  code_t   gray_d, gray_q;
  logic [1:0] valid_d, valid_q;
  therm_t  therm_tc;
  code_t   bin;

  adc_comparator_ladder u_ladder (
    .diff     (diff_q),
    .therm_tc (therm_tc)
  );

  always_comb begin
    diff_d = vin_p - vin_n;
  end

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < NUM_COMP; i++) begin
      bin = bin + code_t'(therm_tc[i]);
    end
  end

  always_comb begin
    gray_d  = bin2gray(bin);
    valid_d = {valid_q[0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q  <= '0;
      gray_q  <= '0;
      valid_q <= '0;
    end else begin
      diff_q  <= diff_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
    end
  end

  assign gray_out  = gray_q;
  assign out_valid = valid_q[1];

endmodule

// File: tb/tb_flash_adc_5bit_top.sv
// Self-checking bench for flash_adc_5bit_top: directed codes, threshold edges,
// random streaming, an exhaustive input sweep and reset behaviour.
module tb_flash_adc_5bit_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vin_p = '0;
  logic [7:0] vin_n = '0;
  logic [4:0] gray_out;
  logic       out_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  flash_adc_5bit_top dut (
    .clk       (clk),
    .rst       (rst),
    .vin_p     (vin_p),
    .vin_n     (vin_n),
    .gray_out  (gray_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: number of ladder taps strictly below diff, then Gray-coded.
  function automatic logic [4:0] ref_gray(input int d);
    int b;
    b = (d <= 8) ? 0 : (d - 1) / 8;
    if (b > 31) b = 31;
    return 5'(b ^ (b / 2));
  endfunction

  // Input history as seen at each rising edge.
  logic [1:0] rst_h = 2'b11;
  logic [7:0] d_h0 = '0, d_h1 = '0;
  int unsigned edges = 0;

  always @(posedge clk) begin
    rst_h <= {rst_h[0], rst};
    d_h0  <= vin_p - vin_n;
    d_h1  <= d_h0;
    edges <= edges + 1;
  end

  // Continuous monitor: the output after edge c reflects the sample from edge c-1.
  logic [4:0] prev_gray = '0;
  logic [7:0] prev_d    = '0;
  logic       prev_ok   = 1'b0;

  always @(negedge clk) begin
    logic       exp_valid;
    logic [4:0] exp_gray;
    logic [7:0] step;
    if (edges >= 2) begin
      exp_valid = !rst_h[0] && !rst_h[1];
      exp_gray  = exp_valid ? ref_gray(int'(d_h1)) : 5'd0;
      check_eq("mon_valid", 32'(out_valid), 32'(exp_valid));
      check_eq("mon_gray", 32'(gray_out), 32'(exp_gray));
      step = d_h1 - prev_d;
      if (prev_ok && exp_valid && (step == 8'd1 || step == 8'd255))
        check_eq("gray_step", 32'($countones(gray_out ^ prev_gray) <= 1), 32'd1);
      prev_gray = gray_out;
      prev_d    = d_h1;
      prev_ok   = exp_valid;
    end
  end

  task automatic apply(input logic [7:0] p, input logic [7:0] n,
                       input logic [4:0] exp, input string tag);
    @(negedge clk);
    vin_p = p;
    vin_n = n;
    @(negedge clk);
    @(negedge clk);
    check_eq(tag, 32'(gray_out), 32'(exp));
  endtask

  task automatic apply_diff(input logic [7:0] d, input logic [4:0] exp, input string tag);
    logic [7:0] n;
    n = 8'($urandom_range(0, 255));
    apply(n + d, n, exp, tag);
  endtask

  initial begin
    logic [7:0] hold_p, hold_n;

    repeat (3) begin
      @(negedge clk);
      vin_p = 8'($urandom);
      vin_n = 8'($urandom);
    end
    @(negedge clk);
    check_eq("rst_gray", 32'(gray_out), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_valid_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("rel_valid_e2", 32'(out_valid), 32'd1);

    apply(8'd128, 8'd128, 5'b00000, "d_128_128");
    apply(8'd160, 8'd128, 5'b00010, "d_160_128");
    apply(8'd200, 8'd100, 5'b01010, "d_200_100");
    apply(8'd255, 8'd0,   5'b10000, "d_255_0");
    apply(8'd100, 8'd120, 5'b10011, "d_100_120");
    apply(8'd50,  8'd200, 5'b01011, "d_50_200");
    apply(8'd180, 8'd100, 5'b01101, "d_180_100");

    apply_diff(8'd8,   5'b00000, "thr_8");
    apply_diff(8'd9,   5'b00001, "thr_9");
    apply_diff(8'd16,  5'b00001, "thr_16");
    apply_diff(8'd17,  5'b00011, "thr_17");
    apply_diff(8'd248, 5'b10001, "thr_248");
    apply_diff(8'd249, 5'b10000, "thr_249");

    repeat (300) begin
      @(negedge clk);
      vin_p = 8'($urandom);
      vin_n = 8'($urandom);
    end

    for (int p = 0; p < 256; p++) begin
      for (int n = 0; n < 256; n++) begin
        @(negedge clk);
        vin_p = 8'(p);
        vin_n = 8'(n);
      end
    end

    repeat (5) begin
      @(negedge clk);
      vin_p = 8'($urandom_range(100, 255));
      vin_n = 8'($urandom_range(0, 90));
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_gray", 32'(gray_out), 32'd0);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    hold_p = 8'd230;
    hold_n = 8'd30;
    vin_p  = hold_p;
    vin_n  = hold_n;
    rst    = 1'b0;
    @(negedge clk);
    check_eq("no_stale_gray", 32'(gray_out), 32'd0);
    check_eq("no_stale_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    check_eq("post_rst_gray", 32'(gray_out), 32'(ref_gray(int'(hold_p - hold_n))));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
